// File: rtl/linear_sensor_ctrl.sv
// linear_sensor_ctrl: multi-frame acquisition controller for Hamamatsu-style
// linear image sensors. Reads integration time and frame count from the config
// RAM, drives the sensor reset/integration pulse, waits for AD_SP and emits a
// per-pixel valid strobe with pixel and frame indices.
// Optional feature: define LSC_SP_TIMEOUT_EN to bound the AD_SP wait to
// TIMEOUT_CYC cycles (timeout_o pulses and the block returns to IDLE).
module linear_sensor_ctrl #(
  parameter int         PIX_NUM     = 512,
  parameter int         BLANK_CYC   = 24,
  parameter logic [7:0] INTEG_ADDR  = 8'h01,
  parameter logic [7:0] FRAMES_ADDR = 8'h02,
  parameter int         TIMEOUT_CYC = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_in,
  input  logic                       soft_reset_in,
  input  logic                       ad_sp,
  output logic                       sensor_clk,
  output logic                       reset_o,
  output logic                       pix_valid_o,
  output logic [$clog2(PIX_NUM)-1:0] pix_idx_o,
  output logic [15:0]                frame_idx_o,
  output logic                       busy_o,
  output logic                       frame_done_o,
  output logic                       done_o,
  output logic                       timeout_o,
  output logic                       cfg_ram_rd_o,
  output logic [7:0]                 cfg_ram_addr_o,
  input  logic [31:0]                cfg_ram_din
);

  localparam int BLANK_W = $clog2(BLANK_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, CFG_RD, CFG_INT, CFG_FRM, INTEG, WAIT_SP, DATA, BLANK
  } state_t;

  state_t               state;
  logic                 start_q;
  logic                 start_rise;
  logic [31:0]          integ;
  logic [15:0]          frames;
  logic [31:0]          integ_cnt;
  logic [BLANK_W-1:0]   blank_cnt;
  logic                 last_frame;
  logic                 last_pix;
  logic                 last_blank;
  logic                 pre_blank;

  // An integration time of zero would never end the INTEG count; run it for one cycle.
  function automatic logic [31:0] clamp_integ(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

  assign sensor_clk = ~clk;
  assign start_rise = start_in & ~start_q;
  assign last_frame = (frames != 16'd0) && (frame_idx_o == frames - 16'd1);
  assign last_pix   = (int'(pix_idx_o) == PIX_NUM - 1);
  assign last_blank = (int'(blank_cnt) == BLANK_CYC - 1);
  // One cycle ahead of the last blank cycle, so the registered pulses land in it.
  assign pre_blank  = (int'(blank_cnt) == BLANK_CYC - 2);

`ifdef LSC_SP_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_expired;
  assign wait_expired = (int'(wait_cnt) == TIMEOUT_CYC - 1);
`else
  assign timeout_o = 1'b0;
`endif

  // Configuration words are plain data taken from the RAM read port; no reset.
  always_ff @(posedge clk) begin
    if (state == CFG_INT) integ  <= clamp_integ(cfg_ram_din);
    if (state == CFG_FRM) frames <= cfg_ram_din[15:0];
  end

  // Acquisition FSM with registered outputs; soft abort overrides every active state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      start_q        <= 1'b1;
      reset_o        <= 1'b0;
      pix_valid_o    <= 1'b0;
      pix_idx_o      <= '0;
      frame_idx_o    <= '0;
      busy_o         <= 1'b0;
      frame_done_o   <= 1'b0;
      done_o         <= 1'b0;
      cfg_ram_rd_o   <= 1'b0;
      cfg_ram_addr_o <= '0;
      integ_cnt      <= '0;
      blank_cnt      <= '0;
`ifdef LSC_SP_TIMEOUT_EN
      wait_cnt       <= '0;
      timeout_o      <= 1'b0;
`endif
    end else begin
      start_q      <= start_in;
      reset_o      <= 1'b0;
      pix_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
      done_o       <= 1'b0;
      cfg_ram_rd_o <= 1'b0;
`ifdef LSC_SP_TIMEOUT_EN
      timeout_o    <= 1'b0;
`endif
      if ((state != IDLE) && soft_reset_in) begin
        state  <= IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_rise) begin
              state          <= CFG_RD;
              busy_o         <= 1'b1;
              cfg_ram_rd_o   <= 1'b1;
              cfg_ram_addr_o <= INTEG_ADDR;
            end
          end
          CFG_RD: begin
            cfg_ram_rd_o   <= 1'b1;
            cfg_ram_addr_o <= FRAMES_ADDR;
            state          <= CFG_INT;
          end
          CFG_INT: state <= CFG_FRM;
          CFG_FRM: begin
            frame_idx_o <= '0;
            integ_cnt   <= '0;
            state       <= INTEG;
          end
          INTEG: begin
            reset_o <= 1'b1;
            if (integ_cnt == integ - 32'd1) begin
              state <= WAIT_SP;
`ifdef LSC_SP_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end else begin
              integ_cnt <= integ_cnt + 32'd1;
            end
          end
          WAIT_SP: begin
            if (ad_sp) begin
              pix_valid_o <= 1'b1;
              pix_idx_o   <= '0;
              state       <= DATA;
`ifdef LSC_SP_TIMEOUT_EN
            end else if (wait_expired) begin
              timeout_o <= 1'b1;
              busy_o    <= 1'b0;
              state     <= IDLE;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
`endif
            end
          end
          DATA: begin
            if (last_pix) begin
              blank_cnt    <= '0;
              frame_done_o <= (BLANK_CYC == 1);
              done_o       <= (BLANK_CYC == 1) && last_frame;
              state        <= BLANK;
            end else begin
              pix_valid_o <= 1'b1;
              pix_idx_o   <= pix_idx_o + 1'b1;
            end
          end
          BLANK: begin
            blank_cnt    <= blank_cnt + 1'b1;
            frame_done_o <= pre_blank;
            done_o       <= pre_blank && last_frame;
            if (last_blank) begin
              if (last_frame) begin
                busy_o <= 1'b0;
                state  <= IDLE;
              end else begin
                frame_idx_o <= frame_idx_o + 16'd1;
                integ_cnt   <= '0;
                state       <= INTEG;
              end
            end
          end
          default: begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_linear_sensor_ctrl.sv
// Bench for linear_sensor_ctrl: randomized runs checked cycle by cycle against
// an event schedule built from integration time, AD_SP gaps and frame counts.
`timescale 1ns/1ps
module tb_linear_sensor_ctrl;

  localparam int         PIX_NUM     = 8;
  localparam int         BLANK_CYC   = 4;
  localparam int         TIMEOUT_CYC = 16;
  localparam logic [7:0] INTEG_ADDR  = 8'h01;
  localparam logic [7:0] FRAMES_ADDR = 8'h02;
  localparam int         MAXC        = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_in = 1'b1;
  logic        soft_reset_in = 1'b0;
  logic        ad_sp = 1'b0;
  logic        sensor_clk, reset_o, pix_valid_o, busy_o, frame_done_o, done_o, timeout_o, cfg_ram_rd_o;
  logic [2:0]  pix_idx_o;
  logic [15:0] frame_idx_o;
  logic [7:0]  cfg_ram_addr_o;
  logic [31:0] cfg_ram_din = '0;
  logic [31:0] mem [256];

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        rs;
    logic        pv;
    logic [2:0]  pidx;
    logic [15:0] fidx;
    logic        fd;
    logic        dn;
    logic        busy;
    logic        rd;
    logic [7:0]  addr;
    logic        to;
  } snap_t;

  snap_t act  [MAXC];
  snap_t expv [MAXC];
  logic  st_in [MAXC];
  logic  sr_in [MAXC];
  logic  ad_in [MAXC];
  int    gap [8];
  int    run_len;
  int    end_cyc;
  int    wait_entry;

  linear_sensor_ctrl #(
    .PIX_NUM(PIX_NUM), .BLANK_CYC(BLANK_CYC), .INTEG_ADDR(INTEG_ADDR),
    .FRAMES_ADDR(FRAMES_ADDR), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .soft_reset_in(soft_reset_in), .ad_sp(ad_sp),
    .sensor_clk(sensor_clk), .reset_o(reset_o), .pix_valid_o(pix_valid_o), .pix_idx_o(pix_idx_o),
    .frame_idx_o(frame_idx_o), .busy_o(busy_o), .frame_done_o(frame_done_o), .done_o(done_o),
    .timeout_o(timeout_o), .cfg_ram_rd_o(cfg_ram_rd_o), .cfg_ram_addr_o(cfg_ram_addr_o),
    .cfg_ram_din(cfg_ram_din)
  );

  always #5 clk = ~clk;

  // Synchronous config RAM: data valid the cycle after the read strobe.
  always @(posedge clk) if (cfg_ram_rd_o) cfg_ram_din <= mem[cfg_ram_addr_o];

  task automatic rand_gaps();
    for (int i = 0; i < 8; i++) gap[i] = $urandom_range(0, 3);
  endtask

  // Expected schedule: cycle 0 carries the start edge; the first INTEG cycle is 4;
  // reset_o is high for integ cycles after each INTEG start; AD_SP seen in cycle k
  // gives pixels in k+1..k+PIX_NUM and the last blank cycle is k+PIX_NUM+BLANK_CYC.
  task automatic plan_run(input logic [31:0] integ_raw, input logic [15:0] frames_cfg,
                          input int nframes, input int abort_frame, input int abort_pix,
                          input bit no_sp, input int glitch_frame);
    int integ, s, k, a, blast;
    for (int c = 0; c < MAXC; c++) begin
      expv[c] = '0; act[c] = '0; st_in[c] = 1'b0; sr_in[c] = 1'b0; ad_in[c] = 1'b0;
    end
    mem[INTEG_ADDR]  = integ_raw;
    mem[FRAMES_ADDR] = {16'($urandom), frames_cfg};
    integ = (integ_raw == 32'd0) ? 1 : int'(integ_raw);
    st_in[0] = 1'b1;
    expv[1].rd = 1'b1; expv[1].addr = INTEG_ADDR;
    expv[2].rd = 1'b1; expv[2].addr = FRAMES_ADDR;
    s = 4;
    end_cyc = -1;
    for (int f = 0; f < nframes && end_cyc < 0; f++) begin
      for (int c = s + 1; c <= s + integ; c++) expv[c].rs = 1'b1;
      ad_in[s] = 1'b1;
      wait_entry = s + integ;
      if (no_sp) begin
`ifdef LSC_SP_TIMEOUT_EN
        expv[wait_entry + TIMEOUT_CYC].to = 1'b1;
        end_cyc = wait_entry + TIMEOUT_CYC - 1;
        sr_in[wait_entry + TIMEOUT_CYC + 4] = 1'b1;
`else
        a = wait_entry + TIMEOUT_CYC + 4;
        sr_in[a] = 1'b1;
        end_cyc = a;
`endif
      end else begin
        k = wait_entry + gap[f];
        ad_in[k] = 1'b1;
        ad_in[k + 2] = 1'b1;
        if (f == glitch_frame) st_in[k + 3] = 1'b1;
        for (int p = 0; p < PIX_NUM; p++) begin
          if (f != abort_frame || p <= abort_pix) begin
            expv[k + 1 + p].pv   = 1'b1;
            expv[k + 1 + p].pidx = 3'(p);
            expv[k + 1 + p].fidx = 16'(f);
          end
        end
        if (f == abort_frame) begin
          a = k + 1 + abort_pix;
          sr_in[a] = 1'b1;
          end_cyc = a;
        end else begin
          blast = k + PIX_NUM + BLANK_CYC;
          expv[blast].fd = 1'b1;
          ad_in[blast] = 1'b1;
          if (frames_cfg != 16'd0 && f == int'(frames_cfg) - 1) begin
            expv[blast].dn = 1'b1;
            end_cyc = blast;
          end
          s = blast + 1;
        end
      end
    end
    for (int c = 1; c <= end_cyc; c++) expv[c].busy = 1'b1;
    run_len = end_cyc + 8;
  endtask

  // Drive the planned inputs and record the outputs seen in each cycle.
  task automatic run_cycles();
    for (int c = 0; c < run_len; c++) begin
      @(negedge clk);
      act[c].rs   = reset_o;      act[c].pv   = pix_valid_o;
      act[c].pidx = pix_idx_o;    act[c].fidx = frame_idx_o;
      act[c].fd   = frame_done_o; act[c].dn   = done_o;
      act[c].busy = busy_o;       act[c].rd   = cfg_ram_rd_o;
      act[c].addr = cfg_ram_addr_o; act[c].to = timeout_o;
      start_in = st_in[c]; soft_reset_in = sr_in[c]; ad_sp = ad_in[c];
    end
    start_in = 1'b0; soft_reset_in = 1'b0; ad_sp = 1'b0;
  endtask

  function automatic int first_diff();
    for (int c = 0; c < run_len; c++) begin
      snap_t a, e;
      a = act[c]; e = expv[c];
      if (a.rs !== e.rs || a.pv !== e.pv || a.fd !== e.fd || a.dn !== e.dn ||
          a.busy !== e.busy || a.rd !== e.rd || a.to !== e.to) return c;
      if (e.pv && (a.pidx !== e.pidx || a.fidx !== e.fidx)) return c;
      if (e.rd && a.addr !== e.addr) return c;
    end
    return -1;
  endfunction

  // sel: 0 reset_o, 1 pix_valid_o, 2 frame_done_o, 3 done_o, 4 timeout_o
  function automatic logic pick(input int c, input int sel);
    case (sel)
      0: return act[c].rs;
      1: return act[c].pv;
      2: return act[c].fd;
      3: return act[c].dn;
      default: return act[c].to;
    endcase
  endfunction

  function automatic int count_act(input int sel);
    int n = 0;
    for (int c = 0; c < run_len; c++) if (pick(c, sel) === 1'b1) n++;
    return n;
  endfunction

  function automatic int last_cycle(input int sel);
    int l = -1;
    for (int c = 0; c < run_len; c++) if (pick(c, sel) === 1'b1) l = c;
    return l;
  endfunction

  task automatic test_reset();
    int bad = 0;
    rst = 1'b1; start_in = 1'b1; soft_reset_in = 1'b0; ad_sp = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({reset_o, pix_valid_o, busy_o, frame_done_o, done_o, timeout_o, cfg_ram_rd_o,
         cfg_ram_addr_o, pix_idx_o, frame_idx_o} !== 37'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b %b %b %b %b %b %b %h %h %h required all zero",
               reset_o, pix_valid_o, busy_o, frame_done_o, done_o, timeout_o, cfg_ram_rd_o,
               cfg_ram_addr_o, pix_idx_o, frame_idx_o);
    end
    checks++;
    if (sensor_clk !== ~clk) begin
      failures++;
      $display("FAIL sensor_clk got=%b required=%b", sensor_clk, ~clk);
    end
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (busy_o !== 1'b0 || cfg_ram_rd_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL start_held_through_reset busy/rd cycles got=%0d required=0", bad);
    end
    start_in = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_frame();
    int d;
    rand_gaps(); gap[0] = 3;
    plan_run(32'd5, 16'd1, 1, -1, 0, 1'b0, -1);
    run_cycles();
    d = first_diff(); checks++;
    if (d >= 0) begin failures++; $display("FAIL single_trace cycle=%0d got=%h required=%h", d, act[d], expv[d]); end
    checks++;
    if (count_act(0) != 5) begin failures++; $display("FAIL single_reset_len got=%0d required=5", count_act(0)); end
    checks++;
    if (count_act(1) != PIX_NUM) begin failures++; $display("FAIL single_pix_count got=%0d required=%0d", count_act(1), PIX_NUM); end
    checks++;
    if (count_act(3) != 1 || last_cycle(3) != end_cyc) begin
      failures++; $display("FAIL single_done got count=%0d at=%0d required 1 at %0d", count_act(3), last_cycle(3), end_cyc);
    end
  endtask

  task automatic test_multi_frame();
    int d;
    rand_gaps();
    plan_run(32'($urandom_range(1, 6)), 16'd3, 3, -1, 0, 1'b0, -1);
    run_cycles();
    d = first_diff(); checks++;
    if (d >= 0) begin failures++; $display("FAIL multi_trace cycle=%0d got=%h required=%h", d, act[d], expv[d]); end
    checks++;
    if (count_act(2) != 3) begin failures++; $display("FAIL multi_frame_done got=%0d required=3", count_act(2)); end
    checks++;
    if (count_act(3) != 1 || last_cycle(3) != end_cyc) begin
      failures++; $display("FAIL multi_done got count=%0d at=%0d required 1 at %0d", count_act(3), last_cycle(3), end_cyc);
    end
    checks++;
    if (count_act(1) != 3 * PIX_NUM) begin failures++; $display("FAIL multi_pix_count got=%0d required=%0d", count_act(1), 3 * PIX_NUM); end
  endtask

  task automatic test_continuous();
    int d, ap;
    rand_gaps();
    ap = $urandom_range(0, PIX_NUM - 1);
    plan_run(32'($urandom_range(1, 4)), 16'd0, 5, 4, ap, 1'b0, -1);
    run_cycles();
    d = first_diff(); checks++;
    if (d >= 0) begin failures++; $display("FAIL cont_trace cycle=%0d got=%h required=%h", d, act[d], expv[d]); end
    checks++;
    if (count_act(3) != 0) begin failures++; $display("FAIL cont_no_done got=%0d required=0", count_act(3)); end
    checks++;
    if (count_act(2) != 4) begin failures++; $display("FAIL cont_frame_done got=%0d required=4", count_act(2)); end
    checks++;
    if (act[end_cyc + 1].busy !== 1'b0 || act[end_cyc + 1].pv !== 1'b0) begin
      failures++; $display("FAIL cont_abort busy=%b pv=%b required 0 0", act[end_cyc + 1].busy, act[end_cyc + 1].pv);
    end
  endtask

  task automatic test_integ_zero();
    int d;
    rand_gaps();
    plan_run(32'd0, 16'd1, 1, -1, 0, 1'b0, -1);
    run_cycles();
    d = first_diff(); checks++;
    if (d >= 0) begin failures++; $display("FAIL integ0_trace cycle=%0d got=%h required=%h", d, act[d], expv[d]); end
    checks++;
    if (count_act(0) != 1) begin failures++; $display("FAIL integ0_reset_len got=%0d required=1", count_act(0)); end
  endtask

  task automatic test_start_during_data();
    int d;
    rand_gaps();
    plan_run(32'($urandom_range(1, 6)), 16'd2, 2, -1, 0, 1'b0, 0);
    run_cycles();
    d = first_diff(); checks++;
    if (d >= 0) begin failures++; $display("FAIL start_glitch_trace cycle=%0d got=%h required=%h", d, act[d], expv[d]); end
    checks++;
    if (count_act(3) != 1) begin failures++; $display("FAIL start_glitch_done got=%0d required=1", count_act(3)); end
  endtask

  task automatic test_timeout();
    int d, exp_to;
    logic exp_busy;
`ifdef LSC_SP_TIMEOUT_EN
    exp_to = 1; exp_busy = 1'b0;
`else
    exp_to = 0; exp_busy = 1'b1;
`endif
    rand_gaps();
    plan_run(32'd3, 16'd1, 1, -1, 0, 1'b1, -1);
    run_cycles();
    d = first_diff(); checks++;
    if (d >= 0) begin failures++; $display("FAIL timeout_trace cycle=%0d got=%h required=%h", d, act[d], expv[d]); end
    checks++;
    if (count_act(4) != exp_to) begin failures++; $display("FAIL timeout_count got=%0d required=%0d", count_act(4), exp_to); end
    checks++;
    if (act[wait_entry + TIMEOUT_CYC + 1].busy !== exp_busy) begin
      failures++; $display("FAIL timeout_busy got=%b required=%b", act[wait_entry + TIMEOUT_CYC + 1].busy, exp_busy);
    end
  endtask

  task automatic test_back_to_back();
    int d, nf;
    for (int r = 0; r < 3; r++) begin
      rand_gaps();
      nf = $urandom_range(1, 3);
      plan_run(32'($urandom_range(0, 7)), 16'(nf), nf, -1, 0, 1'b0, -1);
      run_cycles();
      d = first_diff(); checks++;
      if (d >= 0) begin failures++; $display("FAIL b2b_trace run=%0d cycle=%0d got=%h required=%h", r, d, act[d], expv[d]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    test_reset();
    test_single_frame();
    test_multi_frame();
    test_continuous();
    test_integ_zero();
    test_start_during_data();
    test_timeout();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
